// File: rtl/raisin64_core_pkg.sv
`default_nettype none
//==============================================================================
// Module : raisin64_core_pkg
// Brief  : Opcodes, width codes, FSM states and decode helpers for the core
// Rev    : 1.0
//==============================================================================
package raisin64_core_pkg;

    localparam logic [5:0] c_OP_NOP  = 6'h00;
    localparam logic [5:0] c_OP_ADD  = 6'h01;
    localparam logic [5:0] c_OP_SUB  = 6'h02;
    localparam logic [5:0] c_OP_AND  = 6'h03;
    localparam logic [5:0] c_OP_OR   = 6'h04;
    localparam logic [5:0] c_OP_XOR  = 6'h05;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_LD   = 6'h10;
    localparam logic [5:0] c_OP_ST   = 6'h11;
    localparam logic [5:0] c_OP_SB   = 6'h12;
    localparam logic [5:0] c_OP_BEQ  = 6'h18;
    localparam logic [5:0] c_OP_JAL  = 6'h19;
    localparam logic [5:0] c_OP_HALT = 6'h3F;

    localparam logic [1:0] c_W64 = 2'b00;
    localparam logic [1:0] c_W8  = 2'b11;

    localparam logic [63:0] c_IO_BASE = 64'hFFFF_FFFF_FFFF_0000;

    typedef enum logic [2:0] {
        F_REQ    = 3'd0,
        F_WAIT   = 3'd1,
        EXEC     = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        HALTED   = 3'd5
    } state_t;

    function automatic logic [63:0] sext_imm(input logic [31:0] imm);
        return {{32{imm[31]}}, imm};
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == c_OP_LD) || (op == c_OP_ST) || (op == c_OP_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/raisin64_regfile.sv
`default_nettype none
//==============================================================================
// Module : raisin64_regfile
// Brief  : 64 x 64-bit register file, two async reads, one sync write, r0 = 0
// Rev    : 1.0
//==============================================================================
module raisin64_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_ra1,
    input  logic [5:0]  i_ra2,
    output logic [63:0] o_rd1,
    output logic [63:0] o_rd2,
    input  logic        i_we,
    input  logic [5:0]  i_wa,
    input  logic [63:0] i_wd
);

    logic [63:0] w_regs [64];

    // r0 has no storage; writes to it simply have nowhere to land
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < 64; gi++) begin : g_reg
        logic [63:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (i_we && (i_wa == 6'(gi))) begin
                r_q <= i_wd;
            end
        end
        assign w_regs[gi] = r_q;
    end

    assign o_rd1 = w_regs[i_ra1];
    assign o_rd2 = w_regs[i_ra2];

endmodule
`default_nettype wire

// File: rtl/raisin64_core.sv
`default_nettype none
//==============================================================================
// Module : raisin64_core
// Brief  : Multi-cycle Raisin64 execution core with split instr/data ports
// Rev    : 1.0
//==============================================================================
module raisin64_core
    import raisin64_core_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    output logic        imem_addr_valid,
    input  logic [63:0] imem_data,
    input  logic        imem_data_valid,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_dout,
    input  logic [63:0] dmem_din,
    input  logic        dmem_cycle_complete,
    output logic [1:0]  dmem_write_width,
    output logic        dmem_rstrobe,
    output logic        dmem_wstrobe
);

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_ir;
    logic        r_imem_addr_valid;
    logic [63:0] r_dmem_addr;
    logic [63:0] r_dmem_dout;
    logic [1:0]  r_dmem_width;
    logic        r_dmem_rstrobe;
    logic        r_dmem_wstrobe;

    logic [5:0]  w_op;
    logic [5:0]  w_rd;
    logic [5:0]  w_rs1;
    logic [5:0]  w_rs2;
    logic [63:0] w_imm;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_ea;
    logic [63:0] w_pc_plus8;
    logic [63:0] w_alu;
    logic        w_alu_wr;
    logic        w_we;
    logic [63:0] w_wd;
    logic        w_unused_ir;

    assign w_op        = r_ir[63:58];
    assign w_rd        = r_ir[57:52];
    assign w_rs1       = r_ir[51:46];
    assign w_rs2       = r_ir[45:40];
    assign w_imm       = sext_imm(r_ir[31:0]);
    assign w_unused_ir = ^r_ir[39:32];

    assign w_ea       = w_a + w_imm;
    assign w_pc_plus8 = r_pc + 64'd8;

    raisin64_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_a),
        .o_rd2 (w_b),
        .i_we  (w_we),
        .i_wa  (w_rd),
        .i_wd  (w_wd)
    );

    always_comb begin
        w_alu    = '0;
        w_alu_wr = 1'b1;
        case (w_op)
            c_OP_ADD:  w_alu = w_a + w_b;
            c_OP_SUB:  w_alu = w_a - w_b;
            c_OP_AND:  w_alu = w_a & w_b;
            c_OP_OR:   w_alu = w_a | w_b;
            c_OP_XOR:  w_alu = w_a ^ w_b;
            c_OP_ADDI: w_alu = w_ea;
            c_OP_JAL:  w_alu = w_pc_plus8;
            default:   w_alu_wr = 1'b0;
        endcase
    end

    // Single write port shared by EXEC results and load returns
    always_comb begin
        w_we = 1'b0;
        w_wd = '0;
        if ((r_state == EXEC) && w_alu_wr) begin
            w_we = 1'b1;
            w_wd = w_alu;
        end else if ((r_state == MEM_WAIT) && dmem_cycle_complete && (w_op == c_OP_LD)) begin
            w_we = 1'b1;
            w_wd = dmem_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= F_REQ;
            r_pc              <= RESET_PC;
            r_ir              <= '0;
            r_imem_addr_valid <= 1'b0;
            r_dmem_addr       <= '0;
            r_dmem_dout       <= '0;
            r_dmem_width      <= c_W64;
            r_dmem_rstrobe    <= 1'b0;
            r_dmem_wstrobe    <= 1'b0;
        end else begin
            case (r_state)
                F_REQ: begin
                    r_imem_addr_valid <= 1'b1;
                    r_state           <= F_WAIT;
                end
                F_WAIT: begin
                    r_imem_addr_valid <= 1'b0;
                    if (imem_data_valid) begin
                        r_ir    <= imem_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_mem_op(w_op)) begin
                        r_dmem_addr  <= w_ea;
                        r_dmem_dout  <= w_b;
                        r_dmem_width <= (w_op == c_OP_SB) ? c_W8 : c_W64;
                        r_state      <= MEM_REQ;
                    end else if (w_op == c_OP_HALT) begin
                        r_state <= HALTED;
                    end else begin
                        if (w_op == c_OP_BEQ) begin
                            r_pc <= (w_a == w_b) ? (r_pc + w_imm) : w_pc_plus8;
                        end else if (w_op == c_OP_JAL) begin
                            r_pc <= w_ea & ~64'h7;
                        end else begin
                            r_pc <= w_pc_plus8;
                        end
                        r_state <= F_REQ;
                    end
                end
                MEM_REQ: begin
                    r_dmem_rstrobe <= (w_op == c_OP_LD);
                    r_dmem_wstrobe <= (w_op != c_OP_LD);
                    r_state        <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    r_dmem_rstrobe <= 1'b0;
                    r_dmem_wstrobe <= 1'b0;
                    if (dmem_cycle_complete) begin
                        r_pc    <= w_pc_plus8;
                        r_state <= F_REQ;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= F_REQ;
                end
            endcase
        end
    end

    assign imem_addr        = {r_pc[63:3], 3'b000};
    assign imem_addr_valid  = r_imem_addr_valid;
    assign dmem_addr        = r_dmem_addr;
    assign dmem_dout        = r_dmem_dout;
    assign dmem_write_width = r_dmem_width;
    assign dmem_rstrobe     = r_dmem_rstrobe;
    assign dmem_wstrobe     = r_dmem_wstrobe;

endmodule
`default_nettype wire

// File: tb/tb_raisin64_core.sv
`default_nettype none
//==============================================================================
// Module : tb_raisin64_core
// Brief  : Directed and random programs checked against an ISA-level model
// Rev    : 1.0
//==============================================================================
module tb_raisin64_core;

    typedef struct packed {
        logic        w;
        logic [63:0] addr;
        logic [63:0] dout;
        logic [1:0]  width;
    } dtxn_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic [63:0] imem_data;
    logic        imem_data_valid;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_dout;
    logic [63:0] dmem_din;
    logic        dmem_cycle_complete;
    logic [1:0]  dmem_write_width;
    logic        dmem_rstrobe;
    logic        dmem_wstrobe;

    int n_chk;
    int n_fail;

    logic [63:0] prog     [64];
    logic [63:0] mem_init [256];
    logic [63:0] mem_d    [256];
    logic [63:0] obs_f[$];
    logic [63:0] exp_f[$];
    dtxn_t       obs_d[$];
    dtxn_t       exp_d[$];
    bit          bad_pulse, bad_both, bad_ovl, bad_stable, timed_out;

    raisin64_core dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .imem_addr           (imem_addr),
        .imem_addr_valid     (imem_addr_valid),
        .imem_data           (imem_data),
        .imem_data_valid     (imem_data_valid),
        .dmem_addr           (dmem_addr),
        .dmem_dout           (dmem_dout),
        .dmem_din            (dmem_din),
        .dmem_cycle_complete (dmem_cycle_complete),
        .dmem_write_width    (dmem_write_width),
        .dmem_rstrobe        (dmem_rstrobe),
        .dmem_wstrobe        (dmem_wstrobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] enc(input logic [5:0] op, input logic [5:0] rd,
                                        input logic [5:0] rs1, input logic [5:0] rs2,
                                        input logic [31:0] imm);
        return {op, rd, rs1, rs2, 8'h00, imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction-set interpreter: produces the expected fetch and data traces
    task automatic model_run();
        logic [63:0] regs [64];
        logic [63:0] mm [256];
        logic [63:0] pc, ir, a, b, imm, ea, npc, res;
        logic [5:0]  op, rd;
        bit          wr, done;
        dtxn_t       t;
        for (int i = 0; i < 64; i++) regs[i] = '0;
        for (int i = 0; i < 256; i++) mm[i] = mem_init[i];
        exp_f.delete();
        exp_d.delete();
        pc   = 64'h0;
        done = 1'b0;
        for (int s = 0; s < 400 && !done; s++) begin
            exp_f.push_back({pc[63:3], 3'b000});
            ir  = prog[pc[8:3]];
            op  = ir[63:58];
            rd  = ir[57:52];
            a   = regs[ir[51:46]];
            b   = regs[ir[45:40]];
            imm = {{32{ir[31]}}, ir[31:0]};
            ea  = a + imm;
            npc = pc + 64'd8;
            wr  = 1'b0;
            res = '0;
            case (op)
                6'h01: begin res = a + b; wr = 1'b1; end
                6'h02: begin res = a - b; wr = 1'b1; end
                6'h03: begin res = a & b; wr = 1'b1; end
                6'h04: begin res = a | b; wr = 1'b1; end
                6'h05: begin res = a ^ b; wr = 1'b1; end
                6'h08: begin res = ea;    wr = 1'b1; end
                6'h10: begin
                    res = mm[ea[10:3]]; wr = 1'b1;
                    t = '{w: 1'b0, addr: ea, dout: 64'h0, width: 2'b00};
                    exp_d.push_back(t);
                end
                6'h11: begin
                    mm[ea[10:3]] = b;
                    t = '{w: 1'b1, addr: ea, dout: b, width: 2'b00};
                    exp_d.push_back(t);
                end
                6'h12: begin
                    mm[ea[10:3]][{ea[2:0], 3'b000} +: 8] = b[7:0];
                    t = '{w: 1'b1, addr: ea, dout: b, width: 2'b11};
                    exp_d.push_back(t);
                end
                6'h18: if (a == b) npc = pc + imm;
                6'h19: begin res = pc + 64'd8; wr = 1'b1; npc = ea & ~64'h7; end
                6'h3F: done = 1'b1;
                default: ;
            endcase
            if (wr && rd != 6'd0) regs[rd] = res;
            pc = npc;
        end
    endtask

    // Resets the DUT, then acts as instruction and data memory until idle
    task automatic dut_run(input int dlat, input bit stop_on_dreq);
        int          cyc, idle, icnt, dcnt;
        bit          ipend, dpend, prev_iv;
        logic [63:0] iaddr;
        dtxn_t       cur;
        obs_f.delete();
        obs_d.delete();
        for (int i = 0; i < 256; i++) mem_d[i] = mem_init[i];
        bad_pulse = 0; bad_both = 0; bad_ovl = 0; bad_stable = 0; timed_out = 0;
        rst_n = 1'b0;
        imem_data = '0; imem_data_valid = 1'b0;
        dmem_din = '0;  dmem_cycle_complete = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_imem_valid", 64'(imem_addr_valid), 64'h0);
        chk("rst_rstrobe", 64'(dmem_rstrobe), 64'h0);
        chk("rst_wstrobe", 64'(dmem_wstrobe), 64'h0);
        chk("rst_dmem_addr", dmem_addr, 64'h0);
        chk("rst_dmem_dout", dmem_dout, 64'h0);
        chk("rst_width", 64'(dmem_write_width), 64'h0);
        rst_n = 1'b1;
        ipend = 0; dpend = 0; prev_iv = 0; icnt = 0; dcnt = 0; iaddr = '0;
        cyc = 0; idle = 0;
        while (idle < 100 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            idle++;
            if (imem_addr_valid === 1'b1) begin
                obs_f.push_back(imem_addr);
                if (prev_iv) bad_pulse = 1;
                if (ipend || dpend) bad_ovl = 1;
                ipend = 1; icnt = $urandom_range(0, 2); iaddr = imem_addr;
                idle = 0;
            end
            prev_iv = (imem_addr_valid === 1'b1);
            if (dmem_rstrobe === 1'b1 && dmem_wstrobe === 1'b1) bad_both = 1;
            if (dmem_rstrobe === 1'b1 || dmem_wstrobe === 1'b1) begin
                if (dpend || ipend) bad_ovl = 1;
                cur.w     = dmem_wstrobe;
                cur.addr  = dmem_addr;
                cur.dout  = dmem_wstrobe ? dmem_dout : 64'h0;
                cur.width = dmem_write_width;
                obs_d.push_back(cur);
                if (dmem_wstrobe) begin
                    if (dmem_write_width == 2'b11)
                        mem_d[dmem_addr[10:3]][{dmem_addr[2:0], 3'b000} +: 8] = dmem_dout[7:0];
                    else
                        mem_d[dmem_addr[10:3]] = dmem_dout;
                end
                cur.dout = dmem_dout;
                dpend = 1; dcnt = (dlat >= 0) ? dlat : $urandom_range(0, 3);
                idle = 0;
                if (stop_on_dreq) return;
            end else if (dpend && (dmem_addr !== cur.addr || dmem_dout !== cur.dout
                                   || dmem_write_width !== cur.width)) begin
                bad_stable = 1;
            end
            imem_data_valid = 1'b0;
            dmem_cycle_complete = 1'b0;
            if (ipend) begin
                if (icnt == 0) begin
                    imem_data_valid = 1'b1;
                    imem_data = prog[iaddr[8:3]];
                    ipend = 0;
                end else icnt--;
            end
            if (dpend) begin
                if (dcnt == 0) begin
                    dmem_cycle_complete = 1'b1;
                    dmem_din = mem_d[cur.addr[10:3]];
                    dpend = 0;
                end else dcnt--;
            end
        end
        timed_out = (idle < 100);
    endtask

    task automatic compare_traces(input string tag);
        chk({tag, "_halted"}, 64'(timed_out), 64'h0);
        chk({tag, "_fetch_count"}, 64'(obs_f.size()), 64'(exp_f.size()));
        for (int i = 0; i < exp_f.size(); i++)
            if (i < obs_f.size())
                chk($sformatf("%s_fetch%0d", tag, i), obs_f[i], exp_f[i]);
        chk({tag, "_data_count"}, 64'(obs_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++)
            if (i < obs_d.size()) begin
                chk($sformatf("%s_daddr%0d", tag, i), obs_d[i].addr, exp_d[i].addr);
                chk($sformatf("%s_ddout%0d", tag, i), obs_d[i].dout, exp_d[i].dout);
                chk($sformatf("%s_dkind%0d", tag, i), 64'({obs_d[i].w, obs_d[i].width}),
                    64'({exp_d[i].w, exp_d[i].width}));
            end
        chk({tag, "_fetch_pulse"}, 64'(bad_pulse), 64'h0);
        chk({tag, "_both_strobes"}, 64'(bad_both), 64'h0);
        chk({tag, "_overlap"}, 64'(bad_ovl), 64'h0);
        chk({tag, "_dmem_stable"}, 64'(bad_stable), 64'h0);
    endtask

    task automatic load_directed();
        for (int i = 0; i < 64; i++) prog[i] = enc(6'h3F, 0, 0, 0, 0);
        prog[0]  = enc(6'h08, 1, 0, 0, 32'd5);          // ADDI r1,r0,5
        prog[1]  = enc(6'h08, 2, 0, 0, 32'hFFFF_FFFE);  // ADDI r2,r0,-2
        prog[2]  = enc(6'h01, 3, 1, 2, 0);              // ADD r3
        prog[3]  = enc(6'h02, 4, 2, 1, 0);              // SUB r4
        prog[4]  = enc(6'h11, 0, 0, 3, 32'h10);         // ST r3 -> 0x10
        prog[5]  = enc(6'h11, 0, 0, 4, 32'h18);
        prog[6]  = enc(6'h12, 0, 0, 1, 32'h21);         // SB r1 -> 0x21
        prog[7]  = enc(6'h10, 5, 0, 0, 32'h10);         // LD r5 <- 0x10
        prog[8]  = enc(6'h11, 0, 0, 5, 32'h30);
        prog[9]  = enc(6'h18, 0, 1, 1, 32'd24);         // BEQ taken -> 0x60
        prog[10] = enc(6'h08, 9, 0, 0, 32'd1);
        prog[11] = enc(6'h08, 9, 0, 0, 32'd1);
        prog[12] = enc(6'h18, 0, 1, 2, 32'd24);         // BEQ not taken
        prog[13] = enc(6'h19, 6, 0, 0, 32'h88);         // JAL r6 -> 0x88
        prog[17] = enc(6'h11, 0, 0, 6, 32'h40);
        prog[18] = enc(6'h08, 0, 0, 0, 32'd7);          // ADDI r0 discarded
        prog[19] = enc(6'h01, 7, 0, 0, 0);
        prog[20] = enc(6'h11, 0, 0, 7, 32'h48);
        prog[21] = enc(6'h2A, 2, 1, 1, 32'd9);          // undefined op -> NOP
        prog[22] = enc(6'h11, 0, 0, 2, 32'h50);
    endtask

    task automatic gen_random();
        logic [5:0]  rd, rs1, rs2, op;
        logic [31:0] imm;
        for (int i = 0; i < 64; i++) prog[i] = enc(6'h3F, 0, 0, 0, 0);
        for (int i = 0; i < 48; i++) begin
            rd  = 6'($urandom_range(0, 7));
            rs1 = 6'($urandom_range(0, 7));
            rs2 = 6'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 2: prog[i] = enc(6'h08, rd, rs1, 0, $urandom);
                1: prog[i] = enc(6'($urandom_range(1, 5)), rd, rs1, rs2, 0);
                3: prog[i] = enc(6'h10, rd, 0, 0, 32'($urandom_range(0, 31) * 8));
                4: prog[i] = enc(6'h11, 0, 0, rs2, 32'($urandom_range(0, 31) * 8));
                5: prog[i] = enc(6'h12, 0, 0, rs2, 32'($urandom_range(0, 255)));
                6, 7: begin
                    imm = 32'($urandom_range(1, 3) * 8);
                    if ($urandom_range(0, 3) == 0) imm = imm + 32'($urandom_range(1, 7));
                    prog[i] = enc(6'h18, 0, rs1, ($urandom_range(0, 1) == 1) ? rs1 : rs2, imm);
                end
                8: prog[i] = enc(6'h19, rd, 0, 0,
                                 32'(i * 8 + $urandom_range(1, 3) * 8 + $urandom_range(0, 7)));
                default: begin
                    case ($urandom_range(0, 4))
                        0: op = 6'h00;
                        1: op = 6'h06;
                        2: op = 6'h0F;
                        3: op = 6'h1A;
                        default: op = 6'h2A;
                    endcase
                    prog[i] = enc(op, rd, rs1, rs2, $urandom);
                end
            endcase
        end
        for (int r = 1; r < 8; r++)
            prog[47 + r] = enc(6'h11, 0, 0, 6'(r), 32'(32'h400 + r * 8));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        imem_data = '0; imem_data_valid = 1'b0;
        dmem_din = '0;  dmem_cycle_complete = 1'b0;
        for (int i = 0; i < 256; i++) mem_init[i] = {$urandom, $urandom};

        // Directed program with fixed 4-cycle data latency
        load_directed();
        dut_run(4, 1'b0);
        model_run();
        compare_traces("dir");
        if (obs_f.size() >= 13) begin
            chk("dir_pc0", obs_f[0], 64'h0);
            chk("dir_pc1", obs_f[1], 64'h8);
            chk("dir_pc2", obs_f[2], 64'h10);
            chk("dir_beq_taken", obs_f[10], 64'h60);
            chk("dir_beq_not_taken", obs_f[11], 64'h68);
            chk("dir_jal_target", obs_f[12], 64'h88);
        end
        if (obs_d.size() >= 8) begin
            chk("dir_st_addr", obs_d[0].addr, 64'h10);
            chk("dir_st_r3", obs_d[0].dout, 64'h3);
            chk("dir_st_width", 64'({obs_d[0].w, obs_d[0].width}), 64'h4);
            chk("dir_sub_r4", obs_d[1].dout, 64'hFFFF_FFFF_FFFF_FFF9);
            chk("dir_sb_width", 64'(obs_d[2].width), 64'h3);
            chk("dir_sb_addr", obs_d[2].addr, 64'h21);
            chk("dir_sb_dout", obs_d[2].dout, 64'h5);
            chk("dir_ld_kind", 64'(obs_d[3].w), 64'h0);
            chk("dir_ld_r5", obs_d[4].dout, 64'h3);
            chk("dir_jal_link", obs_d[5].dout, 64'h70);
            chk("dir_r0_r7", obs_d[6].dout, 64'h0);
            chk("dir_undef_nop", obs_d[7].dout, 64'hFFFF_FFFF_FFFF_FFFE);
        end

        // Random programs with random memory latencies
        for (int r = 0; r < 3; r++) begin
            gen_random();
            for (int i = 0; i < 256; i++) mem_init[i] = {$urandom, $urandom};
            dut_run(-1, 1'b0);
            model_run();
            compare_traces($sformatf("rnd%0d", r));
        end

        // Reset asserted while a store is outstanding
        load_directed();
        dut_run(4, 1'b1);
        chk("abort_wstrobe_seen", 64'(dmem_wstrobe), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wstrobe", 64'(dmem_wstrobe), 64'h0);
        chk("abort_rstrobe", 64'(dmem_rstrobe), 64'h0);
        chk("abort_imem_addr", imem_addr, 64'h0);
        chk("abort_imem_valid", 64'(imem_addr_valid), 64'h0);
        chk("abort_dmem_addr", dmem_addr, 64'h0);
        repeat (5) @(negedge clk);
        chk("abort_held_wstrobe", 64'(dmem_wstrobe), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
